div_seq_param: RTL and testbench

//  Parametrised multi-cycle integer divider; next generation of the 8-bit div block.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_step.sv | 24 ++
 rtl/div_seq_param.sv | 129 ++++++++++++
 tb/tb_div_seq_param.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: state encoding and operand helpers shared by the sequential divider.
package div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
      ST_DONE
   } div_state_t;

   // Widest operand abs_w can condition; divider instances must not exceed it.
   localparam int unsigned ABS_MAX_W = 64;

   // Magnitude of the low 'width' bits of value (zero-extended by the caller).
   // Signed MIN maps onto itself, which is the correct unsigned magnitude.
   function automatic logic [ABS_MAX_W-1:0] abs_w(
      input logic [ABS_MAX_W-1:0] value,
      input int unsigned          width,
      input logic                 is_signed
   );
      logic [ABS_MAX_W-1:0] sign_bit;
      sign_bit = (value >> (width - 1)) & ABS_MAX_W'(1);
      if (is_signed && (sign_bit != '0)) return '0 - value;
      return value;
   endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
module div_step #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH+1:0] rem_shift;
   logic             fits;

   // Shift the next dividend bit into the remainder and subtract when the divisor fits
   always_comb begin
      rem_shift = {rem_in, quo_in[WIDTH-1]};
      fits      = (rem_shift >= (WIDTH+2)'(divisor));
      quo_out   = {quo_in[WIDTH-2:0], fits};
      rem_out   = (WIDTH+1)'(rem_shift);
      if (fits) rem_out = (WIDTH+1)'(rem_shift - (WIDTH+2)'(divisor));
   end

endmodule

// File: rtl/div_seq_param.sv
// div_seq_param: multi-cycle signed/unsigned divider with start/busy handshake,
// divide-by-zero flag and fixed WIDTH+2 cycle latency.
module div_seq_param
   import div_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             out_valid,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   div_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   rem_q, rem_step;
   logic [WIDTH-1:0] quo_q, quo_step;
   logic [WIDTH-1:0] dvs_q, a_q;
   logic             neg_quo_q, neg_rem_q, dbz_q;
   logic             is_signed, sign_a, sign_b;
   logic [WIDTH-1:0] abs_a, abs_b;

   // Operand conditioning for the request currently on the inputs
   always_comb begin
      is_signed = SIGNED_EN && signed_mode;
      sign_a    = is_signed && A[WIDTH-1];
      sign_b    = is_signed && B[WIDTH-1];
      abs_a     = WIDTH'(abs_w(ABS_MAX_W'(A), WIDTH, is_signed));
      abs_b     = WIDTH'(abs_w(ABS_MAX_W'(B), WIDTH, is_signed));
   end

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .divisor (dvs_q),
      .rem_out (rem_step),
      .quo_out (quo_step)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and handshake outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_CALC;
         ST_CALC: begin
            busy = 1'b1;
            if (cnt == '0) state_nxt = ST_FIX;
         end
         ST_FIX: begin
            busy      = 1'b1;
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture, restoring iterations and sign-corrected result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         a_q         <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         dbz_q       <= 1'b0;
         Q           <= '0;
         R           <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_q       <= A;
                  quo_q     <= abs_a;
                  dvs_q     <= abs_b;
                  rem_q     <= '0;
                  neg_quo_q <= sign_a ^ sign_b;
                  neg_rem_q <= sign_a;
                  dbz_q     <= (B == '0);
                  cnt       <= CNT_W'(WIDTH - 1);
               end
            end
            ST_CALC: begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               cnt   <= cnt - CNT_W'(1);
            end
            ST_FIX: begin
               div_by_zero <= dbz_q;
               if (dbz_q) begin
                  Q <= '1;
                  R <= a_q;
               end else begin
                  Q <= neg_quo_q ? ('0 - quo_q) : quo_q;
                  R <= neg_rem_q ? ('0 - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq_param.sv
// tb_div_seq_param: scoreboard bench for div_seq_param at WIDTH=8 and WIDTH=16.
module tb_div_seq_param;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8, sm8, busy8, ov8, dz8;
   logic [7:0]  a8, b8, q8, r8;
   logic        start16, sm16, busy16, ov16, dz16;
   logic [15:0] a16, b16, q16, r16;

   exp_t sb8[$];
   exp_t sb16[$];
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   div_seq_param #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .A(a8), .B(b8),
      .busy(busy8), .out_valid(ov8), .Q(q8), .R(r8), .div_by_zero(dz8)
   );

   div_seq_param #(.WIDTH(16), .SIGNED_EN(1'b1)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .A(a16), .B(b16),
      .busy(busy16), .out_valid(ov16), .Q(q16), .R(r16), .div_by_zero(dz16)
   );

   // Reference: native truncating / and %, with the B==0 rule
   function automatic exp_t model(input int unsigned w, input logic [15:0] a,
                                  input logic [15:0] b, input bit s);
      exp_t        e;
      logic [15:0] mask;
      longint      ai, bi, qi, ri;
      mask = 16'((32'd1 << w) - 32'd1);
      e.dz = ((b & mask) == 16'd0);
      if (e.dz) begin
         e.q = mask;
         e.r = a & mask;
         return e;
      end
      ai = longint'({48'd0, a & mask});
      bi = longint'({48'd0, b & mask});
      if (s && a[4'(w - 1)]) ai = ai - (longint'(1) << w);
      if (s && b[4'(w - 1)]) bi = bi - (longint'(1) << w);
      qi = ai / bi;
      ri = ai % bi;
      e.q = 16'(qi) & mask;
      e.r = 16'(ri) & mask;
      return e;
   endfunction

   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit s);
      start8 = 1'b1; a8 = a; b8 = b; sm8 = s;
      sb8.push_back(model(8, {8'd0, a}, {8'd0, b}, s));
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~s;
   endtask

   task automatic issue16(input logic [15:0] a, input logic [15:0] b, input bit s);
      start16 = 1'b1; a16 = a; b16 = b; sm16 = s;
      sb16.push_back(model(16, a, b, s));
      @(negedge clk);
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sm16 = ~s;
   endtask

   // lat counts cycles from the start cycle to the cycle where out_valid is seen
   task automatic wait_ov8(output int lat, output bit seen);
      lat = 1; seen = 1'b0;
      while (lat < 40 && !seen) begin
         if (ov8 === 1'b1) seen = 1'b1;
         else begin @(negedge clk); lat++; end
      end
   endtask

   task automatic wait_ov16(output int lat, output bit seen);
      lat = 1; seen = 1'b0;
      while (lat < 60 && !seen) begin
         if (ov16 === 1'b1) seen = 1'b1;
         else begin @(negedge clk); lat++; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy8 !== 1'b0) $display("FAIL reset busy: got %b want 0", busy8); else passed++;
      checks++; if (ov8 !== 1'b0) $display("FAIL reset out_valid: got %b want 0", ov8); else passed++;
      checks++; if (q8 !== 8'h00) $display("FAIL reset Q: got %h want 00", q8); else passed++;
      checks++; if (r8 !== 8'h00) $display("FAIL reset R: got %h want 00", r8); else passed++;
      checks++; if (dz8 !== 1'b0) $display("FAIL reset div_by_zero: got %b want 0", dz8); else passed++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unsigned();
      logic [7:0] ta [5] = '{8'd127, 8'd0, 8'd64, 8'd127, 8'd1};
      logic [7:0] tb_b [5] = '{8'd92, 8'd78, 8'd8, 8'd127, 8'd7};
      exp_t e; int lat; bit seen;
      for (int i = 0; i < 5; i++) begin
         issue8(ta[i], tb_b[i], 1'b0);
         wait_ov8(lat, seen);
         e = sb8.pop_front();
         checks++; if (!seen || lat != 10) $display("FAIL unsigned[%0d] latency: got %0d (seen=%0b) want 10", i, lat, seen); else passed++;
         checks++; if (q8 !== e.q[7:0]) $display("FAIL unsigned[%0d] Q: got %0d want %0d", i, q8, e.q[7:0]); else passed++;
         checks++; if (r8 !== e.r[7:0]) $display("FAIL unsigned[%0d] R: got %0d want %0d", i, r8, e.r[7:0]); else passed++;
         checks++; if (dz8 !== e.dz) $display("FAIL unsigned[%0d] div_by_zero: got %b want %b", i, dz8, e.dz); else passed++;
         @(negedge clk);
         checks++; if (ov8 !== 1'b0) $display("FAIL unsigned[%0d] pulse width: out_valid still %b, want 0", i, ov8); else passed++;
      end
   endtask

   task automatic test_signed();
      logic [7:0] ta [3] = '{8'hF9, 8'h07, 8'h80};
      logic [7:0] tb_b [3] = '{8'h02, 8'hFE, 8'hFF};
      exp_t e; int lat; bit seen;
      for (int i = 0; i < 3; i++) begin
         issue8(ta[i], tb_b[i], 1'b1);
         wait_ov8(lat, seen);
         e = sb8.pop_front();
         checks++; if (!seen || lat != 10) $display("FAIL signed[%0d] latency: got %0d (seen=%0b) want 10", i, lat, seen); else passed++;
         checks++; if (q8 !== e.q[7:0]) $display("FAIL signed[%0d] Q: got %h want %h", i, q8, e.q[7:0]); else passed++;
         checks++; if (r8 !== e.r[7:0]) $display("FAIL signed[%0d] R: got %h want %h", i, r8, e.r[7:0]); else passed++;
         checks++; if (dz8 !== e.dz) $display("FAIL signed[%0d] div_by_zero: got %b want %b", i, dz8, e.dz); else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_div_zero();
      exp_t e; int lat; bit seen;
      for (int i = 0; i < 2; i++) begin
         issue8(8'h05, 8'h00, (i == 1));
         wait_ov8(lat, seen);
         e = sb8.pop_front();
         checks++; if (!seen || lat != 10) $display("FAIL div0[%0d] latency: got %0d (seen=%0b) want 10", i, lat, seen); else passed++;
         checks++; if (q8 !== e.q[7:0]) $display("FAIL div0[%0d] Q: got %h want %h", i, q8, e.q[7:0]); else passed++;
         checks++; if (r8 !== e.r[7:0]) $display("FAIL div0[%0d] R: got %h want %h", i, r8, e.r[7:0]); else passed++;
         checks++; if (dz8 !== e.dz) $display("FAIL div0[%0d] div_by_zero: got %b want %b", i, dz8, e.dz); else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e; int lat; bit seen; bit busy_ok;
      issue8(8'd100, 8'd7, 1'b0);
      lat = 1; seen = 1'b0; busy_ok = 1'b1;
      while (lat < 40 && !seen) begin
         if (ov8 === 1'b1) seen = 1'b1;
         else begin
            if (busy8 !== 1'b1) busy_ok = 1'b0;
            start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom_range(1, 255)); sm8 = 1'b1;
            @(negedge clk); lat++;
         end
      end
      e = sb8.pop_front();
      checks++; if (!busy_ok) $display("FAIL busy_hold: busy dropped before out_valid, want 1"); else passed++;
      checks++; if (!seen || lat != 10) $display("FAIL busy_ignore latency: got %0d (seen=%0b) want 10", lat, seen); else passed++;
      checks++; if ({q8, r8} !== {e.q[7:0], e.r[7:0]}) $display("FAIL busy_ignore Q/R: got %0d/%0d want %0d/%0d", q8, r8, e.q[7:0], e.r[7:0]); else passed++;
      // start held high through the DONE cycle must also be ignored
      start8 = 1'b1; a8 = 8'd3; b8 = 8'd1; sm8 = 1'b0;
      @(negedge clk);
      issue8(8'd50, 8'd6, 1'b0);
      wait_ov8(lat, seen);
      e = sb8.pop_front();
      checks++; if (!seen || lat != 10) $display("FAIL back_to_back latency: got %0d (seen=%0b) want 10", lat, seen); else passed++;
      checks++; if ({q8, r8} !== {e.q[7:0], e.r[7:0]}) $display("FAIL back_to_back Q/R: got %0d/%0d want %0d/%0d", q8, r8, e.q[7:0], e.r[7:0]); else passed++;
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      exp_t e; int lat; bit seen; int ov_count;
      issue8(8'd99, 8'd4, 1'b0);
      void'(sb8.pop_back());
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (busy8 !== 1'b0) $display("FAIL abort busy: got %b want 0", busy8); else passed++;
      checks++; if (ov8 !== 1'b0) $display("FAIL abort out_valid: got %b want 0", ov8); else passed++;
      checks++; if ({q8, r8} !== 16'h0000) $display("FAIL abort Q/R: got %h/%h want 00/00", q8, r8); else passed++;
      rst = 1'b0;
      ov_count = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (ov8 === 1'b1) ov_count++;
      end
      checks++; if (ov_count != 0) $display("FAIL abort no_result: got %0d out_valid pulses want 0", ov_count); else passed++;
      issue8(8'd200, 8'd13, 1'b0);
      wait_ov8(lat, seen);
      e = sb8.pop_front();
      checks++; if (!seen || lat != 10) $display("FAIL after_abort latency: got %0d (seen=%0b) want 10", lat, seen); else passed++;
      checks++; if ({q8, r8} !== {e.q[7:0], e.r[7:0]}) $display("FAIL after_abort Q/R: got %0d/%0d want %0d/%0d", q8, r8, e.q[7:0], e.r[7:0]); else passed++;
      @(negedge clk);
   endtask

   task automatic test_random8(input int n);
      exp_t e; int lat; bit seen; logic [7:0] a, b; bit s;
      for (int i = 0; i < n; i++) begin
         a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
         case ($urandom_range(0, 9))
            0: b = 8'h00;
            1: begin a = 8'h80; b = 8'hFF; end
            default: ;
         endcase
         issue8(a, b, s);
         wait_ov8(lat, seen);
         e = sb8.pop_front();
         checks++;
         if (!seen || lat != 10 || q8 !== e.q[7:0] || r8 !== e.r[7:0] || dz8 !== e.dz)
            $display("FAIL rand8[%0d] %h/%h s=%0b: got Q=%h R=%h dz=%b lat=%0d want Q=%h R=%h dz=%b lat=10",
                     i, a, b, s, q8, r8, dz8, lat, e.q[7:0], e.r[7:0], e.dz);
         else passed++;
         if (!seen) return;
         @(negedge clk);
      end
   endtask

   task automatic test_random16(input int n);
      exp_t e; int lat; bit seen; logic [15:0] a, b; bit s;
      for (int i = 0; i < n; i++) begin
         a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
         case ($urandom_range(0, 9))
            0: b = 16'h0000;
            1: begin a = 16'h8000; b = 16'hFFFF; end
            2: b = 16'($urandom_range(1, 15));
            default: ;
         endcase
         issue16(a, b, s);
         wait_ov16(lat, seen);
         e = sb16.pop_front();
         checks++;
         if (!seen || lat != 18 || q16 !== e.q || r16 !== e.r || dz16 !== e.dz)
            $display("FAIL rand16[%0d] %h/%h s=%0b: got Q=%h R=%h dz=%b lat=%0d want Q=%h R=%h dz=%b lat=18",
                     i, a, b, s, q16, r16, dz16, lat, e.q, e.r, e.dz);
         else passed++;
         if (!seen) return;
         @(negedge clk);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
      start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_back_to_back();
      test_reset_abort();
      test_random8(2000);
      test_random16(2000);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
